// File: rtl/asrv32_mem_arbiter.sv
// Two-port (instruction fetch / load-store) round-robin arbiter onto one shared memory bus.
// Optional access timeout with bus-error response is enabled by defining ASRV32_ARB_TIMEOUT_EN.
module asrv32_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        i_clk,
    input  logic        rst_n,
    input  logic        i_inst_stb,
    input  logic [31:0] i_inst_addr,
    output logic        o_inst_ack,
    output logic [31:0] o_inst_data,
    input  logic        i_data_stb,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wdata,
    input  logic [3:0]  i_data_wr_mask,
    input  logic        i_data_wr_en,
    output logic        o_data_ack,
    output logic [31:0] o_data_rdata,
    output logic        o_mem_stb,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wr_mask,
    output logic        o_mem_wr_en,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_bus_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic        last_grant_r;   // 1 = data port was granted last
    logic        grant_data_r;   // port owning the current transaction
    logic        grant_s;
    logic        grant_data_s;
    logic        mem_done_s;
    logic        timeout_s;
    logic [31:0] resp_data_s;

    logic        inst_ack_r;
    logic [31:0] inst_data_r;
    logic        data_ack_r;
    logic [31:0] data_rdata_r;
    logic        mem_stb_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [3:0]  mem_wr_mask_r;
    logic        mem_wr_en_r;
    logic        bus_err_r;

`ifdef ASRV32_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] tmo_cnt_r;

    // Count WAIT cycles without an acknowledge; restarts on every REQ.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_REQ) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_WAIT) && !i_mem_ack && !timeout_s) begin
            tmo_cnt_r <= tmo_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Timeout fires on the last allowed WAIT cycle, unless the memory answers in it.
    always_comb begin
        if ((state_r == ST_WAIT) && !i_mem_ack &&
            (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Arbitration: a lone requester wins; on contention the port not served last wins.
    always_comb begin
        grant_s = i_inst_stb | i_data_stb;
        if (i_inst_stb && i_data_stb) begin
            grant_data_s = ~last_grant_r;
        end else if (i_data_stb) begin
            grant_data_s = 1'b1;
        end else begin
            grant_data_s = 1'b0;
        end
    end

    // An acknowledge counts only while a request is outstanding (REQ or WAIT).
    always_comb begin
        if (((state_r == ST_REQ) || (state_r == ST_WAIT)) && i_mem_ack) begin
            mem_done_s = 1'b1;
        end else begin
            mem_done_s = 1'b0;
        end
        if (timeout_s) begin
            resp_data_s = ERR_DATA;
        end else begin
            resp_data_s = i_mem_rdata;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_done_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_done_s || timeout_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, grant capture, memory request and response registers.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            last_grant_r  <= 1'b0;
            grant_data_r  <= 1'b0;
            inst_ack_r    <= 1'b0;
            inst_data_r   <= 32'h0000_0000;
            data_ack_r    <= 1'b0;
            data_rdata_r  <= 32'h0000_0000;
            mem_stb_r     <= 1'b0;
            mem_addr_r    <= 32'h0000_0000;
            mem_wdata_r   <= 32'h0000_0000;
            mem_wr_mask_r <= 4'b0000;
            mem_wr_en_r   <= 1'b0;
            bus_err_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            mem_stb_r   <= 1'b0;
            mem_wr_en_r <= 1'b0;
            inst_ack_r  <= 1'b0;
            data_ack_r  <= 1'b0;
            bus_err_r   <= 1'b0;

            if ((state_r == ST_IDLE) && grant_s) begin
                grant_data_r <= grant_data_s;
                last_grant_r <= grant_data_s;
                mem_stb_r    <= 1'b1;
                if (grant_data_s) begin
                    mem_addr_r    <= i_data_addr;
                    mem_wdata_r   <= i_data_wdata;
                    mem_wr_mask_r <= i_data_wr_mask;
                    mem_wr_en_r   <= i_data_wr_en;
                end else begin
                    mem_addr_r    <= i_inst_addr;
                    mem_wdata_r   <= 32'h0000_0000;
                    mem_wr_mask_r <= 4'b0000;
                    mem_wr_en_r   <= 1'b0;
                end
            end else begin
                grant_data_r <= grant_data_r;
                last_grant_r <= last_grant_r;
            end

            // Response is presented during the RESP cycle, on the owning port only.
            if (mem_done_s || timeout_s) begin
                bus_err_r <= timeout_s;
                if (grant_data_r) begin
                    data_ack_r   <= 1'b1;
                    data_rdata_r <= resp_data_s;
                end else begin
                    inst_ack_r   <= 1'b1;
                    inst_data_r  <= resp_data_s;
                end
            end else begin
                inst_data_r  <= inst_data_r;
                data_rdata_r <= data_rdata_r;
            end
        end
    end

    assign o_inst_ack    = inst_ack_r;
    assign o_inst_data   = inst_data_r;
    assign o_data_ack    = data_ack_r;
    assign o_data_rdata  = data_rdata_r;
    assign o_mem_stb     = mem_stb_r;
    assign o_mem_addr    = mem_addr_r;
    assign o_mem_wdata   = mem_wdata_r;
    assign o_mem_wr_mask = mem_wr_mask_r;
    assign o_mem_wr_en   = mem_wr_en_r;
    assign o_bus_err     = bus_err_r;

endmodule

// File: tb/tb_asrv32_mem_arbiter.sv
// Directed self-checking bench for asrv32_mem_arbiter (timeout case depends on ASRV32_ARB_TIMEOUT_EN).
module tb_asrv32_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        rst_n;
    logic        i_inst_stb;
    logic [31:0] i_inst_addr;
    logic        o_inst_ack;
    logic [31:0] o_inst_data;
    logic        i_data_stb;
    logic [31:0] i_data_addr;
    logic [31:0] i_data_wdata;
    logic [3:0]  i_data_wr_mask;
    logic        i_data_wr_en;
    logic        o_data_ack;
    logic [31:0] o_data_rdata;
    logic        o_mem_stb;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wr_mask;
    logic        o_mem_wr_en;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_bus_err;

    always #5 i_clk = ~i_clk;

    asrv32_mem_arbiter #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .i_clk(i_clk), .rst_n(rst_n),
        .i_inst_stb(i_inst_stb), .i_inst_addr(i_inst_addr),
        .o_inst_ack(o_inst_ack), .o_inst_data(o_inst_data),
        .i_data_stb(i_data_stb), .i_data_addr(i_data_addr), .i_data_wdata(i_data_wdata),
        .i_data_wr_mask(i_data_wr_mask), .i_data_wr_en(i_data_wr_en),
        .o_data_ack(o_data_ack), .o_data_rdata(o_data_rdata),
        .o_mem_stb(o_mem_stb), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_wr_mask(o_mem_wr_mask), .o_mem_wr_en(o_mem_wr_en),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_bus_err(o_bus_err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check32(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Memory model: acks mem_delay cycles after the request pulse (0 = never), or manual drive.
    int          mem_delay = 1;
    logic [31:0] mem_val   = 32'h0;
    bit          manual    = 1'b0;
    logic        man_ack   = 1'b0;
    logic [31:0] man_rdata = 32'h0;
    logic        rsp_ack   = 1'b0;
    bit          pend      = 1'b0;
    int          cnt       = 0;

    assign i_mem_ack   = manual ? man_ack : rsp_ack;
    assign i_mem_rdata = manual ? man_rdata : mem_val;

    always @(negedge i_clk) begin
        rsp_ack = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (cnt == 0) begin
                    rsp_ack = 1'b1;
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (o_mem_stb && mem_delay > 0) begin
                pend = 1'b1;
                cnt = mem_delay - 1;
            end
        end
    end

    // Cumulative event counters and grant log; tests take snapshots.
    int          stb_cnt = 0, iack_cnt = 0, dack_cnt = 0, berr_cnt = 0, wr_cnt = 0;
    logic [31:0] grant_q[$];

    always @(posedge i_clk) begin
        if (o_mem_stb) begin
            stb_cnt <= stb_cnt + 1;
            grant_q.push_back(o_mem_addr);
        end
        if (o_inst_ack)  iack_cnt <= iack_cnt + 1;
        if (o_data_ack)  dack_cnt <= dack_cnt + 1;
        if (o_bus_err)   berr_cnt <= berr_cnt + 1;
        if (o_mem_wr_en) wr_cnt   <= wr_cnt + 1;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check32({tag, "_iack"},  {31'b0, o_inst_ack}, 32'h0);
        check32({tag, "_dack"},  {31'b0, o_data_ack}, 32'h0);
        check32({tag, "_idata"}, o_inst_data, 32'h0);
        check32({tag, "_rdata"}, o_data_rdata, 32'h0);
        check32({tag, "_mstb"},  {31'b0, o_mem_stb}, 32'h0);
        check32({tag, "_maddr"}, o_mem_addr, 32'h0);
        check32({tag, "_mwd"},   o_mem_wdata, 32'h0);
        check32({tag, "_mmask"}, {28'b0, o_mem_wr_mask}, 32'h0);
        check32({tag, "_mwe"},   {31'b0, o_mem_wr_en}, 32'h0);
        check32({tag, "_berr"},  {31'b0, o_bus_err}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1, n, base;
        rst_n = 1'b0;
        i_inst_stb = 1'b0; i_inst_addr = 32'h0;
        i_data_stb = 1'b0; i_data_addr = 32'h0; i_data_wdata = 32'h0;
        i_data_wr_mask = 4'b0000; i_data_wr_en = 1'b0;
        #12;
        check_all_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Single fetch, 1-cycle memory
        mem_delay = 1; mem_val = 32'h0000_0013; s0 = stb_cnt;
        i_inst_addr = 32'h10; i_inst_stb = 1'b1;
        tick();
        check32("f_stb", {31'b0, o_mem_stb}, 32'h1);
        check32("f_addr", o_mem_addr, 32'h10);
        check32("f_we", {31'b0, o_mem_wr_en}, 32'h0);
        tick();
        check32("f_stb_off", {31'b0, o_mem_stb}, 32'h0);
        check32("f_ack_early", {31'b0, o_inst_ack}, 32'h0);
        tick();
        check32("f_ack", {31'b0, o_inst_ack}, 32'h1);
        check32("f_data", o_inst_data, 32'h0000_0013);
        check32("f_dack", {31'b0, o_data_ack}, 32'h0);
        i_inst_stb = 1'b0;
        tick();
        check32("f_ack_pulse", {31'b0, o_inst_ack}, 32'h0);
        check32("f_data_hold", o_inst_data, 32'h0000_0013);
        check32("f_stb_count", stb_cnt - s0, 32'd1);

        // Store
        mem_val = 32'hFFFF_0000; s0 = wr_cnt; s1 = iack_cnt;
        i_data_addr = 32'h40; i_data_wdata = 32'hA5A5_A5A5; i_data_wr_mask = 4'b0011;
        i_data_wr_en = 1'b1; i_data_stb = 1'b1;
        tick();
        check32("s_we", {31'b0, o_mem_wr_en}, 32'h1);
        check32("s_addr", o_mem_addr, 32'h40);
        check32("s_wdata", o_mem_wdata, 32'hA5A5_A5A5);
        check32("s_mask", {28'b0, o_mem_wr_mask}, 32'h3);
        tick();
        check32("s_we_off", {31'b0, o_mem_wr_en}, 32'h0);
        tick();
        check32("s_dack", {31'b0, o_data_ack}, 32'h1);
        check32("s_iack", {31'b0, o_inst_ack}, 32'h0);
        check32("s_rdata", o_data_rdata, 32'hFFFF_0000);
        i_data_stb = 1'b0; i_data_wr_en = 1'b0;
        tick();
        check32("s_dack_pulse", {31'b0, o_data_ack}, 32'h0);
        check32("s_we_count", wr_cnt - s0, 32'd1);
        check32("s_iack_count", iack_cnt - s1, 32'd0);
        check32("s_idata_hold", o_inst_data, 32'h0000_0013);

        // Slow memory: ack 5 cycles after the request
        mem_delay = 5; mem_val = 32'h1234_5678; s0 = stb_cnt;
        i_data_addr = 32'h80; i_data_stb = 1'b1;
        tick();
        n = 0;
        while (!o_data_ack && n < 20) begin
            tick();
            n++;
        end
        check32("slow_lat", n, 32'd6);
        check32("slow_data", o_data_rdata, 32'h1234_5678);
        i_data_stb = 1'b0;
        tick();
        check32("slow_stb_count", stb_cnt - s0, 32'd1);

        // Ack in IDLE ignored; ack in the REQ cycle completes the access
        manual = 1'b1; man_ack = 1'b1; man_rdata = 32'h5555_5555; s0 = dack_cnt;
        tick();
        tick();
        check32("idle_ack_dack", dack_cnt - s0, 32'd0);
        check32("idle_ack_stb", {31'b0, o_mem_stb}, 32'h0);
        man_ack = 1'b0;
        i_data_addr = 32'h300; i_data_stb = 1'b1;
        tick();
        man_ack = 1'b1; man_rdata = 32'h0BAD_F00D;
        tick();
        check32("reqack_dack", {31'b0, o_data_ack}, 32'h1);
        check32("reqack_data", o_data_rdata, 32'h0BAD_F00D);
        man_ack = 1'b0; i_data_stb = 1'b0;
        tick();
        manual = 1'b0;

        // Contention from reset: D,I,D,I
        mem_delay = 1; mem_val = 32'h7777_0000;
        rst_n = 1'b0;
        i_inst_addr = 32'h100; i_data_addr = 32'h200;
        i_inst_stb = 1'b1; i_data_stb = 1'b1;
        tick();
        rst_n = 1'b1;
        base = grant_q.size(); s0 = iack_cnt; s1 = dack_cnt;
        n = 0;
        while ((grant_q.size() - base) < 4 && n < 40) begin
            tick();
            n++;
        end
        i_inst_stb = 1'b0; i_data_stb = 1'b0;
        check32("cont_grants", grant_q.size() - base, 32'd4);
        if ((grant_q.size() - base) >= 4) begin
            check32("cont_g0", grant_q[base],     32'h200);
            check32("cont_g1", grant_q[base + 1], 32'h100);
            check32("cont_g2", grant_q[base + 2], 32'h200);
            check32("cont_g3", grant_q[base + 3], 32'h100);
        end
        repeat (6) tick();
        check32("cont_iacks", iack_cnt - s0, 32'd2);
        check32("cont_dacks", dack_cnt - s1, 32'd2);

        // Reset during WAIT, stale ack after release
        mem_delay = 0; s0 = iack_cnt; s1 = dack_cnt;
        i_data_addr = 32'h500; i_data_stb = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("rstw");
        i_data_stb = 1'b0;
        tick();
        rst_n = 1'b1;
        manual = 1'b1; man_ack = 1'b1; man_rdata = 32'hFFFF_FFFF;
        tick();
        man_ack = 1'b0;
        tick();
        tick();
        check32("rstw_iacks", iack_cnt - s0, 32'd0);
        check32("rstw_dacks", dack_cnt - s1, 32'd0);
        check_all_zero("rstw_after");
        manual = 1'b0;

        // Memory that never answers a load
        mem_delay = 0; s0 = dack_cnt; s1 = berr_cnt;
        i_data_addr = 32'h600; i_data_stb = 1'b1;
        tick();
        n = 0;
`ifdef ASRV32_ARB_TIMEOUT_EN
        while (!o_data_ack && n < 20) begin
            tick();
            n++;
        end
        check32("to_lat", n, 32'd5);
        check32("to_dack", {31'b0, o_data_ack}, 32'h1);
        check32("to_berr", {31'b0, o_bus_err}, 32'h1);
        check32("to_data", o_data_rdata, 32'hDEAD_BEEF);
        i_data_stb = 1'b0;
        tick();
        check32("to_berr_pulse", {31'b0, o_bus_err}, 32'h0);
        check32("to_berr_count", berr_cnt - s1, 32'd1);
`else
        repeat (30) tick();
        check32("noto_dack", dack_cnt - s0, 32'd0);
        check32("noto_berr", berr_cnt - s1, 32'd0);
        check32("noto_berr_total", berr_cnt, 32'd0);
        i_data_stb = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
